imem_loader: RTL and testbench

- Writer side of the processor's instruction memory write port (`a`/`d`/`we`); fetch reads the same memory through `dpra`/`dpo`.
- Accepts a byte stream over a valid/ready handshake and parses a header plus big-endian 32-bit words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Raises `cpu_hold` while loading so the top level can keep PC/core in reset.

---
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: instruction-memory writer fed by a byte stream.
// The stream is a big-endian 16-bit word count followed by that many
// big-endian 32-bit words, written to consecutive addresses from 0.
// cpu_hold stays high for the whole session so the core can be kept in reset.

module imem_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_WORD,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [16:0] DEPTH_X = 17'(DEPTH);

    state_t      state;
    state_t      next_state;
    logic [15:0] count;
    logic [15:0] index;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [15:0] header;
    logic        accept;
    logic        in_range;
    logic        last_word;

    // Full count as it will look once the low header byte is taken.
    assign header    = {count[15:8], byte_data};
    assign accept    = byte_valid && byte_ready;
    // Words past the end of memory are drained but never written.
    assign in_range  = {1'b0, index} < DEPTH_X;
    assign last_word = (index + 16'd1) == count;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; byte_ready depends on state alone.
    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    next_state = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    next_state = (header == 16'd0) ? S_DONE : S_WORD;
                end
            end
            S_WORD: begin
                byte_ready = 1'b1;
                if (byte_valid && (byte_cnt == 2'd3)) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                next_state = last_word ? S_DONE : S_WORD;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; write strobes and done are one-cycle pulses
    // that line up with the WRITE and DONE states respectively.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            index        <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we   <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= (next_state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err          <= 1'b0;
                        words_loaded <= '0;
                        index        <= '0;
                        byte_cnt     <= '0;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        count[15:8] <= byte_data;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        count[7:0] <= byte_data;
                        if ({1'b0, header} > DEPTH_X) begin
                            err <= 1'b1;
                        end
                        if (header == 16'd0) begin
                            done <= 1'b1;
                        end
                    end
                end
                S_WORD: begin
                    if (accept) begin
                        shift    <= {shift[15:0], byte_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if ((byte_cnt == 2'd3) && in_range) begin
                            mem_we   <= 1'b1;
                            mem_addr <= index[ADDR_W-1:0];
                            mem_data <= DATA_W'({shift, byte_data});
                        end
                    end
                end
                S_WRITE: begin
                    if (in_range) begin
                        words_loaded <= words_loaded + 16'd1;
                    end
                    index <= index + 16'd1;
                    if (last_word) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// Expected writes and final status come from decoding the byte stream directly.

module tb_imem_loader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_cons_cyc = 0;
    int hold_gaps = 0;

    logic [7:0]        tx_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                wr_cyc_q[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic              exp_err;
    logic [15:0]       exp_wl;
    int                exp_cnt;

    always @(posedge clk) cyc++;

    // Passive monitor: logs every write strobe and done pulse between edges.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_data);
                wr_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt  = 0;
        hold_gaps = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    // Reference: decode the whole stream into the writes it should cause.
    task automatic build_model();
        exp_addr.delete();
        exp_data.delete();
        exp_cnt = int'({tx_q[0], tx_q[1]});
        for (int k = 0; k < exp_cnt; k++) begin
            if (k < DEPTH) begin
                exp_addr.push_back(ADDR_W'(k));
                exp_data.push_back({tx_q[2+4*k], tx_q[3+4*k], tx_q[4+4*k], tx_q[5+4*k]});
            end
        end
        exp_err = (exp_cnt > DEPTH);
        exp_wl  = 16'((exp_cnt < DEPTH) ? exp_cnt : DEPTH);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers tx_q bytes with probability pct, optionally pulsing start mid-stream.
    task automatic feed(input int pct, input int restart_every, input int budget);
        int idx = 0;
        int n = 0;
        while (idx < tx_q.size() && n < budget) begin
            @(negedge clk);
            start      = (restart_every > 0) && ((n % restart_every) == restart_every - 1);
            byte_valid = ($urandom_range(99) < pct);
            byte_data  = byte_valid ? tx_q[idx] : 8'($urandom);
            if (!cpu_hold) hold_gaps++;
            if (byte_valid && byte_ready) begin
                idx++;
                last_cons_cyc = cyc + 1;
            end
            n++;
        end
        n_vec++;
        if (idx != tx_q.size()) begin
            n_bad++;
            $display("[TB] FAIL feed_timeout consumed=%0d required=%0d", idx, tx_q.size());
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            start      = 1'b0;
            if (!cpu_hold) hold_gaps++;
            if (done) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL done_timeout got=0 required=1");
        end
    endtask

    task automatic run_session(input int pct, input int restart_every);
        clear_logs();
        build_model();
        pulse_start();
        feed(pct, restart_every, 20 * tx_q.size() + 50);
        wait_done(50);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({byte_ready, mem_we, done, cpu_hold, err, words_loaded, mem_addr, mem_data} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs got=%b/%b/%b/%b/%b/%0d/%0d/%h required=all zero",
                     byte_ready, mem_we, done, cpu_hold, err, words_loaded, mem_addr, mem_data);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        tx_q = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20};
        run_session(100, 0);
        n_vec++;
        if (wr_addr_q.size() != 2) begin
            n_bad++;
            $display("[TB] FAIL basic_write_count got=%0d required=2", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                    n_bad++;
                    $display("[TB] FAIL basic_write%0d got=%0d:%h required=%0d:%h",
                             i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
                end
            end
            n_vec++;
            if (wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
                n_bad++;
                $display("[TB] FAIL basic_throughput got=%0d required=5", wr_cyc_q[1] - wr_cyc_q[0]);
            end
            n_vec++;
            if (done_cyc != wr_cyc_q[1] + 1) begin
                n_bad++;
                $display("[TB] FAIL basic_done_latency got=%0d required=%0d", done_cyc, wr_cyc_q[1] + 1);
            end
        end
        n_vec++;
        if (words_loaded !== exp_wl || err !== exp_err || done_cnt != 1) begin
            n_bad++;
            $display("[TB] FAIL basic_status got=wl%0d err%b done%0d required=wl%0d err%b done1",
                     words_loaded, err, done_cnt, exp_wl, exp_err);
        end
        n_vec++;
        if (hold_gaps != 0 || cpu_hold !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL basic_cpu_hold got=gaps%0d after%b required=gaps0 after0", hold_gaps, cpu_hold);
        end
    endtask

    task automatic test_zero();
        tx_q = '{8'h00, 8'h00};
        run_session(100, 0);
        n_vec++;
        if (wr_addr_q.size() != 0 || words_loaded !== 16'd0 || done_cnt != 1) begin
            n_bad++;
            $display("[TB] FAIL zero_status got=writes%0d wl%0d done%0d required=writes0 wl0 done1",
                     wr_addr_q.size(), words_loaded, done_cnt);
        end
        n_vec++;
        if (done_cyc != last_cons_cyc) begin
            n_bad++;
            $display("[TB] FAIL zero_done_latency got=%0d required=%0d", done_cyc, last_cons_cyc);
        end
        n_vec++;
        if (cpu_hold !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL zero_cpu_hold got=%b required=0", cpu_hold);
        end
    endtask

    task automatic test_toggle();
        tx_q = '{8'h00, 8'h01};
        push_word(32'hDEADBEEF);
        run_session(50, 0);
        n_vec++;
        if (wr_addr_q.size() != 1) begin
            n_bad++;
            $display("[TB] FAIL toggle_write_count got=%0d required=1", wr_addr_q.size());
        end else begin
            n_vec++;
            if (wr_addr_q[0] !== exp_addr[0] || wr_data_q[0] !== exp_data[0]) begin
                n_bad++;
                $display("[TB] FAIL toggle_write got=%0d:%h required=%0d:%h",
                         wr_addr_q[0], wr_data_q[0], exp_addr[0], exp_data[0]);
            end
            n_vec++;
            if (done_cyc != wr_cyc_q[0] + 1) begin
                n_bad++;
                $display("[TB] FAIL toggle_done_latency got=%0d required=%0d", done_cyc, wr_cyc_q[0] + 1);
            end
        end
        n_vec++;
        if (words_loaded !== exp_wl || err !== exp_err || done_cnt != 1) begin
            n_bad++;
            $display("[TB] FAIL toggle_status got=wl%0d err%b done%0d required=wl%0d err%b done1",
                     words_loaded, err, done_cnt, exp_wl, exp_err);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 6; s++) begin
            int cnt = $urandom_range(1, 6);
            tx_q = '{8'h00, 8'(cnt)};
            for (int k = 0; k < cnt; k++) push_word($urandom);
            run_session($urandom_range(25, 100), 0);
            n_vec++;
            if (wr_addr_q.size() != exp_addr.size()) begin
                n_bad++;
                $display("[TB] FAIL random%0d_write_count got=%0d required=%0d", s, wr_addr_q.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    n_vec++;
                    if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                        n_bad++;
                        $display("[TB] FAIL random%0d_write%0d got=%0d:%h required=%0d:%h",
                                 s, i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            n_vec++;
            if (words_loaded !== exp_wl || err !== exp_err || done_cnt != 1 || hold_gaps != 0) begin
                n_bad++;
                $display("[TB] FAIL random%0d_status got=wl%0d err%b done%0d gaps%0d required=wl%0d err%b done1 gaps0",
                         s, words_loaded, err, done_cnt, hold_gaps, exp_wl, exp_err);
            end
        end
    endtask

    // Overflowing header, optionally with start pulsed repeatedly mid-session.
    task automatic test_overflow(input int restart_every);
        tx_q = '{8'h02, 8'h01};
        for (int k = 0; k < 513; k++) push_word(32'(k));
        run_session(100, restart_every);
        n_vec++;
        if (wr_addr_q.size() != exp_addr.size()) begin
            n_bad++;
            $display("[TB] FAIL overflow%0d_write_count got=%0d required=%0d",
                     restart_every, wr_addr_q.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                n_vec++;
                if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                    n_bad++;
                    $display("[TB] FAIL overflow%0d_write%0d got=%0d:%h required=%0d:%h",
                             restart_every, i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        n_vec++;
        if (err !== 1'b1 || words_loaded !== 16'd512 || done_cnt != 1) begin
            n_bad++;
            $display("[TB] FAIL overflow%0d_status got=err%b wl%0d done%0d required=err1 wl512 done1",
                     restart_every, err, words_loaded, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0;
        w0 = $urandom;
        clear_logs();
        tx_q = '{8'h00, 8'h03};
        push_word(w0);
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h5A);
        pulse_start();
        feed(100, 0, 200);
        @(negedge clk);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({byte_ready, mem_we, done, cpu_hold, err, words_loaded, mem_addr, mem_data} !== '0) begin
            n_bad++;
            $display("[TB] FAIL abort_outputs got=%b/%b/%b/%b/%b/%0d/%0d/%h required=all zero",
                     byte_ready, mem_we, done, cpu_hold, err, words_loaded, mem_addr, mem_data);
        end
        n_vec++;
        if (wr_addr_q.size() != 1 || (wr_addr_q.size() == 1 && wr_data_q[0] !== w0)) begin
            n_bad++;
            $display("[TB] FAIL abort_pre_writes got=%0d required=1 of %h", wr_addr_q.size(), w0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (done_cnt != 0) begin
            n_bad++;
            $display("[TB] FAIL abort_no_done got=%0d required=0", done_cnt);
        end
        tx_q = '{8'h00, 8'h01};
        push_word($urandom);
        run_session(100, 0);
        n_vec++;
        if (wr_addr_q.size() != 1 || words_loaded !== 16'd1 || done_cnt != 1) begin
            n_bad++;
            $display("[TB] FAIL fresh_status got=writes%0d wl%0d done%0d required=writes1 wl1 done1",
                     wr_addr_q.size(), words_loaded, done_cnt);
        end else begin
            n_vec++;
            if (wr_addr_q[0] !== exp_addr[0] || wr_data_q[0] !== exp_data[0]) begin
                n_bad++;
                $display("[TB] FAIL fresh_write got=%0d:%h required=%0d:%h",
                         wr_addr_q[0], wr_data_q[0], exp_addr[0], exp_data[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_toggle();
        test_random();
        test_overflow(0);
        test_overflow(37);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
